// File: rtl/fil_pulse_gen_if.sv
// fil_pulse_gen_if
//   Groups the data-path signals of fil_pulse_gen. CLK and RST stay plain
//   ports on the module itself.
//   fil_in      : filtered level from the hysteresis filter stage
//   pulse_out   : generated output pulse
//   busy        : sequencer not idle
//   miss_count  : saturating count of rises ignored while busy
//   width_count : length of the last completed high period
//   width_valid : one-cycle strobe when width_count updates
//   Modports: master drives fil_in and observes the rest; slave is the
//   pulse generator.
interface fil_pulse_gen_if;
  logic        fil_in;
  logic        pulse_out;
  logic        busy;
  logic [7:0]  miss_count;
  logic [29:0] width_count;
  logic        width_valid;

  modport master (
    output fil_in,
    input  pulse_out,
    input  busy,
    input  miss_count,
    input  width_count,
    input  width_valid
  );

  modport slave (
    input  fil_in,
    output pulse_out,
    output busy,
    output miss_count,
    output width_count,
    output width_valid
  );
endinterface

// File: rtl/fil_pulse_gen.sv
// fil_pulse_gen
//   Downstream of the moving-window hysteresis filter. Detects clean rising
//   edges on the filtered level, waits WAIT_CYCLES, emits a PULSE_CYCLES-wide
//   pulse, then ignores further rises for HOLDOFF_CYCLES.
//   Parameters:
//     WAIT_CYCLES    : rise-to-pulse delay in clocks (0 allowed)
//     PULSE_CYCLES   : pulse width in clocks (>= 1)
//     HOLDOFF_CYCLES : dead time after the pulse (0 allowed)
//   Ports:
//     CLK : sole clock, all logic on posedge
//     RST : synchronous, active-high reset
//     bus : fil_pulse_gen_if.slave (fil_in, pulse_out, busy, miss_count,
//           width_count, width_valid)
//   Optional feature macro: FIL_WIDTH_MEAS_EN
//     defined   : measures each filtered high period into width_count
//     undefined : width_count and width_valid are tied to 0
module fil_pulse_gen #(
  parameter logic [15:0] WAIT_CYCLES    = 16'd1000,
  parameter logic [15:0] PULSE_CYCLES   = 16'd100,
  parameter logic [15:0] HOLDOFF_CYCLES = 16'd500
) (
  input  logic            CLK,
  input  logic            RST,
  fil_pulse_gen_if.slave  bus
);

  localparam logic [1:0] IDLE           = 2'd0;
  localparam logic [1:0] WAITING        = 2'd1;
  localparam logic [1:0] GENERATE_PULSE = 2'd2;
  localparam logic [1:0] HOLDOFF        = 2'd3;

  // Terminal counts; WAIT/HOLDOFF of 0 bypass their states, so the wrapped
  // value is never compared against.
  localparam logic [15:0] WAIT_LAST    = WAIT_CYCLES - 16'd1;
  localparam logic [15:0] PULSE_LAST   = PULSE_CYCLES - 16'd1;
  localparam logic [15:0] HOLDOFF_LAST = HOLDOFF_CYCLES - 16'd1;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic        fil_d;
  logic        rise;
  logic [7:0]  miss_q;

  // fil_d resets to 0, so a level already high at reset release is a rise.
  assign rise = bus.fil_in & ~fil_d;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          cnt_nx   = '0;
          state_nx = (WAIT_CYCLES == 16'd0) ? GENERATE_PULSE : WAITING;
        end
      end
      WAITING: begin
        // Losing the level aborts, even on the terminal count.
        if (!bus.fil_in) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == WAIT_LAST) begin
          state_nx = GENERATE_PULSE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      GENERATE_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nx   = '0;
          state_nx = (HOLDOFF_CYCLES == 16'd0) ? IDLE : HOLDOFF;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      fil_d <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      fil_d <= bus.fil_in;
    end
  end

  // A rise is judged against the pre-edge state, so one arriving on the
  // edge that returns to IDLE still counts as a miss.
  always_ff @(posedge CLK) begin
    if (RST) begin
      miss_q <= '0;
    end else if (rise && (state != IDLE) && (miss_q != 8'hFF)) begin
      miss_q <= miss_q + 8'd1;
    end
  end

  assign bus.pulse_out  = (state == GENERATE_PULSE);
  assign bus.busy       = (state != IDLE);
  assign bus.miss_count = miss_q;

`ifdef FIL_WIDTH_MEAS_EN
  logic        fall;
  logic [29:0] hcnt;
  logic [29:0] width_q;
  logic        width_v_q;

  assign fall = ~bus.fil_in & fil_d;

  // hcnt holds the number of high samples so far; on the fall edge it still
  // holds the full count of the period just ended.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt      <= '0;
      width_q   <= '0;
      width_v_q <= 1'b0;
    end else begin
      if (bus.fil_in) begin
        if (hcnt != '1) begin
          hcnt <= hcnt + 30'd1;
        end
      end else begin
        hcnt <= '0;
      end
      width_v_q <= fall;
      if (fall) begin
        width_q <= hcnt;
      end
    end
  end

  assign bus.width_count = width_q;
  assign bus.width_valid = width_v_q;
`else
  assign bus.width_count = '0;
  assign bus.width_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fil_pulse_gen.sv
// tb_fil_pulse_gen
//   Two instances share one fil_in: A (WAIT=4, PULSE=3, HOLDOFF=2) and
//   B (WAIT=0, PULSE=1, HOLDOFF=0). Each phase builds a fil_in sample
//   sequence, derives expected pulses, busy windows, miss counts and widths
//   from it, then drives it while a monitor compares DUT output events.
module tb_fil_pulse_gen;

  localparam int NMAX = 2000;
  localparam int TAIL = 16;

  typedef struct {int s; int e;} win_t;
  typedef struct {int k; int h;} wev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic fil = 1'b0;

  always #5 CLK = ~CLK;

  fil_pulse_gen_if bus0();
  fil_pulse_gen_if bus1();

  assign bus0.fil_in = fil;
  assign bus1.fil_in = fil;

  fil_pulse_gen #(
    .WAIT_CYCLES(16'd4), .PULSE_CYCLES(16'd3), .HOLDOFF_CYCLES(16'd2)
  ) dut_a (.CLK(CLK), .RST(RST), .bus(bus0));

  fil_pulse_gen #(
    .WAIT_CYCLES(16'd0), .PULSE_CYCLES(16'd1), .HOLDOFF_CYCLES(16'd0)
  ) dut_b (.CLK(CLK), .RST(RST), .bus(bus1));

  int wc[2] = '{4, 0};
  int pc[2] = '{3, 1};
  int hc[2] = '{2, 0};

  int n_tests = 0;
  int n_fail  = 0;

  bit   stim[NMAX];
  int   nstim;
  int   pulse_q[2][$];
  win_t busy_q[2][$];
  wev_t width_q[2][$];
  int   exp_miss[2][NMAX];
  int   final_miss[2];

  task automatic check(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit sample_at(int idx);
    return (idx < nstim) ? stim[idx] : 1'b0;
  endfunction

  task automatic add(bit v, int n);
    for (int j = 0; j < n; j++) begin
      stim[nstim] = v;
      nstim++;
    end
  endtask

  // Reference: walk the sample sequence. A rise while idle starts a window;
  // it aborts at the first low sample within the next WAIT samples, else a
  // pulse starts WAIT samples later and the window lasts WAIT+PULSE+HOLDOFF.
  // A rise at or before the edge where the window ends is a miss.
  function automatic void model_inst(int i);
    int   last_end = -1;
    int   miss = 0;
    bit   prev = 1'b0;
    bit   ab;
    int   abk;
    win_t w;
    pulse_q[i].delete();
    busy_q[i].delete();
    for (int k = 0; k < nstim; k++) begin
      if (stim[k] && !prev) begin
        if (k > last_end) begin
          ab  = 1'b0;
          abk = 0;
          for (int j = 1; j <= wc[i] && !ab; j++) begin
            if (!sample_at(k + j)) begin
              ab  = 1'b1;
              abk = k + j;
            end
          end
          w.s = k;
          if (ab) begin
            w.e = abk;
          end else begin
            pulse_q[i].push_back(k + wc[i]);
            w.e = k + wc[i] + pc[i] + hc[i];
          end
          busy_q[i].push_back(w);
          last_end = w.e;
        end else if (miss < 255) begin
          miss++;
        end
      end
      exp_miss[i][k] = miss;
      prev = stim[k];
    end
    final_miss[i] = miss;
  endfunction

  function automatic void model_width(int i);
    int   run = 0;
    bit   prev = 1'b0;
    wev_t e;
    width_q[i].delete();
    for (int k = 0; k < nstim; k++) begin
      if (stim[k]) begin
        run++;
      end else begin
        if (prev) begin
          e.k = k;
          e.h = run;
`ifdef FIL_WIDTH_MEAS_EN
          width_q[i].push_back(e);
`endif
        end
        run = 0;
      end
      prev = stim[k];
    end
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    fil = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic driver();
    for (int k = 0; k < nstim; k++) begin
      fil = stim[k];
      @(negedge CLK);
    end
    fil = 1'b0;
  endtask

  task automatic monitor(string tag);
    bit     pp[2] = '{1'b0, 1'b0};
    bit     bp[2] = '{1'b0, 1'b0};
    int     plen[2] = '{0, 0};
    win_t   cur[2];
    bit     p[2];
    bit     b[2];
    bit     wv[2];
    longint m[2];
    longint wcnt[2];
    int     e;
    wev_t   we;
    for (int k = 0; k < nstim; k++) begin
      @(negedge CLK);
      p[0] = bus0.pulse_out;   p[1] = bus1.pulse_out;
      b[0] = bus0.busy;        b[1] = bus1.busy;
      m[0] = bus0.miss_count;  m[1] = bus1.miss_count;
      wv[0] = bus0.width_valid; wv[1] = bus1.width_valid;
      wcnt[0] = bus0.width_count; wcnt[1] = bus1.width_count;
      for (int i = 0; i < 2; i++) begin
        if (p[i] && !pp[i]) begin
          check($sformatf("%s/u%0d pulse_expected@%0d", tag, i, k),
                pulse_q[i].size() > 0, 1);
          if (pulse_q[i].size() > 0) begin
            e = pulse_q[i].pop_front();
            check($sformatf("%s/u%0d pulse_start", tag, i), k, e);
          end
          plen[i] = 1;
        end else if (p[i] && pp[i]) begin
          plen[i]++;
        end else if (!p[i] && pp[i]) begin
          check($sformatf("%s/u%0d pulse_len@%0d", tag, i, k), plen[i], pc[i]);
        end
        if (b[i] && !bp[i]) begin
          check($sformatf("%s/u%0d busy_expected@%0d", tag, i, k),
                busy_q[i].size() > 0, 1);
          if (busy_q[i].size() > 0) begin
            cur[i] = busy_q[i].pop_front();
            check($sformatf("%s/u%0d busy_start", tag, i), k, cur[i].s);
          end
        end else if (!b[i] && bp[i]) begin
          check($sformatf("%s/u%0d busy_end", tag, i), k, cur[i].e);
          check($sformatf("%s/u%0d miss_count@%0d", tag, i, k), m[i], exp_miss[i][k]);
        end
`ifdef FIL_WIDTH_MEAS_EN
        if (wv[i]) begin
          check($sformatf("%s/u%0d width_expected@%0d", tag, i, k),
                width_q[i].size() > 0, 1);
          if (width_q[i].size() > 0) begin
            we = width_q[i].pop_front();
            check($sformatf("%s/u%0d width_time", tag, i), k, we.k);
            check($sformatf("%s/u%0d width_count", tag, i), wcnt[i], we.h);
          end
        end
`else
        check($sformatf("%s/u%0d width_valid@%0d", tag, i, k), wv[i], 0);
`endif
        pp[i] = p[i];
        bp[i] = b[i];
      end
    end
  endtask

  task automatic run_phase(string tag);
    add(1'b0, TAIL);
    for (int i = 0; i < 2; i++) begin
      model_inst(i);
      model_width(i);
    end
    do_reset();
    fork
      driver();
      monitor(tag);
    join
    check({tag, "/u0 final_miss"}, bus0.miss_count, final_miss[0]);
    check({tag, "/u1 final_miss"}, bus1.miss_count, final_miss[1]);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/u%0d pulses_left", tag, i), pulse_q[i].size(), 0);
      check($sformatf("%s/u%0d busy_left", tag, i), busy_q[i].size(), 0);
      check($sformatf("%s/u%0d widths_left", tag, i), width_q[i].size(), 0);
    end
`ifndef FIL_WIDTH_MEAS_EN
    check({tag, "/width_count_tied"}, bus0.width_count, 0);
`endif
    nstim = 0;
  endtask

  task automatic step(bit v);
    fil = v;
    @(negedge CLK);
  endtask

  task automatic reset_mid_pulse();
    do_reset();
    step(1'b1); step(1'b1);           // edges 0,1
    step(1'b0); step(1'b0);           // edge 2 aborts unit A
    for (int j = 0; j < 5; j++) step(1'b1);  // edges 4..8: rise at 4, pulse after 8
    step(1'b0);                       // edge 9
    step(1'b1);                       // edge 10: rise during pulse -> miss
    check("rst/pre_pulse", bus0.pulse_out, 1);
    check("rst/pre_miss", bus0.miss_count, 1);
`ifdef FIL_WIDTH_MEAS_EN
    check("rst/pre_width", bus0.width_count, 5);
`endif
    RST = 1'b1;
    @(negedge CLK);                   // edge 11 applies reset
    check("rst/pulse", bus0.pulse_out, 0);
    check("rst/busy", bus0.busy, 0);
    check("rst/miss", bus0.miss_count, 0);
    check("rst/width", bus0.width_count, 0);
    check("rst/width_valid", bus0.width_valid, 0);
    RST = 1'b0;
    @(negedge CLK);                   // fil still high: first edge is a rise
    check("rst/rise_after_release", bus0.busy, 1);
    for (int j = 0; j < 12; j++) step(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    nstim = 0;

    add(1'b1, 20);
    run_phase("hold20");

    add(1'b1, 2);
    run_phase("abort");

    add(1'b1, 1); add(1'b0, 2); add(1'b1, 1);
    run_phase("w0_retrig");

    add(1'b1, 37);
    run_phase("width37");

    for (int n = 0; n < 150; n++) begin
      add(1'b1, 5); add(1'b0, 1); add(1'b1, 1);
      add(1'b0, 1); add(1'b1, 1); add(1'b0, 1);
    end
    run_phase("saturate");

    for (int r = 0; r < 3; r++) begin
      total = 0;
      add(1'b0, 1);
      while (total < 300) begin
        int h;
        int l;
        h = int'($urandom_range(1, 12));
        l = int'($urandom_range(1, 6));
        add(1'b1, h);
        add(1'b0, l);
        total += h + l;
      end
      run_phase($sformatf("rand%0d", r));
    end

    reset_mid_pulse();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
